cpu_control_fsm: RTL and testbench
==================================

# cpu_control_fsm

Multicycle control state machine for the 16-bit CR16-style core. Sequences fetch, decode and execute phases and drives the instruction register write enable, PC update, register-file write, data-memory strobes and memory-address mux. Sits between the instruction register output and the datapath enables. It is the only block that asserts `ir_we`.

## Interface
- `RESET_PC_SEL`, default 0: value driven on `pc_src` during reset (0 selects PC+1).
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  level; 0 parks the FSM in FETCH before the next instruction starts
- `instr`  in  16  latched instruction from the instruction register
- `cond_true`  in  1  condition evaluation of `instr[11:8]` against PSR flags, valid in DECODE
- `ir_we`  out  1  instruction register load
- `pc_en`  out  1  PC register load
- `pc_src`  out  2  0 = PC+1, 1 = PC+sign-extended disp8, 2 = Rtarget, 3 = reserved
- `mem_addr_sel`  out  1  0 = PC, 1 = Raddr
- `mem_we`  out  1  data memory write strobe
- `rf_we`  out  1  register file write
- `wb_sel`  out  2  0 = ALU, 1 = memory read data, 2 = PC+1 (link)
- `psr_we`  out  1  flag register load
- `state_out`  out  4  current state encoding, for debug

## Operation
- Decode fields: `op = instr[15:12]`, `ext = instr[7:4]`.
- Classes: LOAD (op 4, ext 0), STOR (op 4, ext 4), JCOND (op 4, ext C), JAL (op 4, ext 8), BCOND (op C), ALU (everything else, including immediates). Undefined encodings are treated as ALU with `rf_we` 0 and `psr_we` 0 (NOP).
- States and transitions:
  - FETCH: `mem_addr_sel`=0. Go to LATCH if `run`=1, otherwise stay.
  - LATCH: `ir_we`=1 (BRAM data is valid this cycle). Go to DECODE.
  - DECODE: no enables. ALU→EXEC, LOAD→LD_ADDR, STOR→ST, BCOND/JCOND/JAL→BRANCH.
  - EXEC: `rf_we`=1, `psr_we`=1 for arithmetic/compare ops, `wb_sel`=0, `pc_en`=1, `pc_src`=0. Go to FETCH.
  - LD_ADDR: `mem_addr_sel`=1. Go to LD_WB.
  - LD_WB: `mem_addr_sel`=1, `rf_we`=1, `wb_sel`=1, `pc_en`=1, `pc_src`=0. Go to FETCH.
  - ST: `mem_addr_sel`=1, `mem_we`=1, `pc_en`=1, `pc_src`=0. Go to FETCH.
  - BRANCH: `pc_en`=1.
    - BCOND: `pc_src`=1 if `cond_true`, else 0.
    - JCOND: `pc_src`=2 if `cond_true`, else 0.
    - JAL: `pc_src`=2 unconditionally, plus `rf_we`=1 and `wb_sel`=2.
    - Go to FETCH.
- `cond_true` is sampled into a registered `take` bit in DECODE. BRANCH uses `take`, not the live input.
- All outputs are decoded from the registered state and the registered IR (Moore). No output depends combinationally on `run`.
- Every output defaults to 0 in any state that does not name it.

## Timing
- Reset: state = FETCH, `take` = 0, all strobes 0, `pc_src` = `RESET_PC_SEL`, `wb_sel` = 0, `mem_addr_sel` = 0.
- Reset asserted in any state returns to FETCH on the next edge. No write strobe is asserted in the reset cycle.
- Cycles per instruction: ALU 4, LOAD 5, STOR 4, branch/jump 4.
- `ir_we` is high for exactly one cycle per instruction, always in LATCH.
- `pc_en` is high for exactly one cycle per instruction, always the final state before FETCH.
- `run` deasserted mid-instruction: the current instruction completes, then the FSM holds in FETCH.
- `run` reasserted: LATCH follows on the next edge.
- Illegal state encodings recover to FETCH.

## Structure
- Shared package `cpu_pkg`:
  - state enum
  - opcode/ext localparams (`OP_MEM`=4'h4, `OP_BCOND`=4'hC, `EXT_LOAD`=4'h0, `EXT_STOR`=4'h4, `EXT_JAL`=4'h8, `EXT_JCOND`=4'hC)
  - `pc_src` and `wb_sel` encodings
- One natural sub-module, `instr_class_decode`: combinational op/ext → class one-hot plus psr-writes flag. The FSM instantiates it on `instr`.

## Test plan
- Reset held 3 cycles, then released with `run`=1 and `instr`=16'h0521 (ADD) → state sequence FETCH, LATCH, DECODE, EXEC, FETCH; `ir_we` only in LATCH; `rf_we`=`psr_we`=`pc_en`=1 only in EXEC with `pc_src`=0.
- `instr`=16'h4102 (LOAD) → 5-cycle sequence; `mem_addr_sel`=1 in LD_ADDR and LD_WB; `rf_we`=1, `wb_sel`=1 only in LD_WB.
- `instr`=16'h4143 (STOR) → `mem_we`=1 for exactly one cycle in ST, `rf_we` never asserted.
- BCOND 16'hC0FE with `cond_true`=1 in DECODE and 0 in BRANCH → `pc_src`=1 (registered `take` honoured). Repeat with `cond_true`=0 → `pc_src`=0.
- JAL 16'h4E83 → BRANCH asserts `pc_src`=2, `rf_we`=1, `wb_sel`=2.
- `run` dropped during DECODE of a LOAD → LOAD completes, FSM parks in FETCH with all strobes 0. Separately, `rst` pulsed during ST → `mem_we` 0 in the following cycle and state = FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the CR16-style multicycle control path
// Purpose: state enum, opcode/ext field values, pc_src/wb_sel encodings and
//          the ALU-class tables used by instr_class_decode.
// Ports:   none (package).
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_LATCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_LD_ADDR = 4'd4,
    S_LD_WB   = 4'd5,
    S_ST      = 4'd6,
    S_BRANCH  = 4'd7
  } state_t;

  localparam logic [3:0] OP_REG    = 4'h0;
  localparam logic [3:0] OP_MEM    = 4'h4;
  localparam logic [3:0] OP_BCOND  = 4'hC;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  localparam logic [1:0] PC_SRC_INC  = 2'd0;
  localparam logic [1:0] PC_SRC_DISP = 2'd1;
  localparam logic [1:0] PC_SRC_REG  = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  // Instruction class one-hot bit positions.
  localparam int CLS_W     = 6;
  localparam int CLS_ALU   = 0;
  localparam int CLS_LOAD  = 1;
  localparam int CLS_STOR  = 2;
  localparam int CLS_JCOND = 3;
  localparam int CLS_JAL   = 4;
  localparam int CLS_BCOND = 5;

  // ALU tables, one bit per ext (register form, op 0) or per op (immediates).
  // Flag writers: ADD 2, ADDC 3, SUB 9, CMP B.  Others defined: AND 1, OR 5,
  // XOR 6, MOV D; immediates add shifts (op 8) and LUI (op F).
  localparam logic [15:0] REG_PSR_MASK = 16'h0A0C;
  localparam logic [15:0] REG_DEF_MASK = 16'h2A6E;
  localparam logic [15:0] IMM_PSR_MASK = 16'h0A0C;
  localparam logic [15:0] IMM_DEF_MASK = 16'hAB6E;

endpackage

// File: rtl/instr_class_decode.sv
// rtl/instr_class_decode.sv - op/ext to instruction class one-hot
// Purpose: classify the latched instruction for the control FSM.
// Ports:   op, ext          - instruction fields instr[15:12], instr[7:4]
//          cls              - one-hot class (CLS_* positions)
//          alu_defined      - ALU-class encoding is a real operation (else NOP)
//          psr_writes       - ALU operation updates the flags
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [3:0]       op,
  input  logic [3:0]       ext,
  output logic [CLS_W-1:0] cls,
  output logic             alu_defined,
  output logic             psr_writes
);

  always_comb begin
    cls         = '0;
    alu_defined = 1'b0;
    psr_writes  = 1'b0;
    if (op == OP_MEM && ext == EXT_LOAD) begin
      cls[CLS_LOAD] = 1'b1;
    end else if (op == OP_MEM && ext == EXT_STOR) begin
      cls[CLS_STOR] = 1'b1;
    end else if (op == OP_MEM && ext == EXT_JCOND) begin
      cls[CLS_JCOND] = 1'b1;
    end else if (op == OP_MEM && ext == EXT_JAL) begin
      cls[CLS_JAL] = 1'b1;
    end else if (op == OP_BCOND) begin
      cls[CLS_BCOND] = 1'b1;
    end else begin
      // Any remaining op 4 ext lands here and is absent from both tables -> NOP.
      cls[CLS_ALU] = 1'b1;
      if (op == OP_REG) begin
        alu_defined = REG_DEF_MASK[ext];
        psr_writes  = REG_PSR_MASK[ext];
      end else if (op != OP_MEM) begin
        alu_defined = IMM_DEF_MASK[op];
        psr_writes  = IMM_PSR_MASK[op];
      end
    end
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multicycle fetch/decode/execute control FSM
// Purpose: sequence each instruction and drive datapath enables (Moore).
// Ports:   clk, rst (sync, active-high), run, instr, cond_true
//          ir_we, pc_en, pc_src, mem_addr_sel, mem_we, rf_we, wb_sel,
//          psr_we, state_out
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        cond_true,
  output logic        ir_we,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        mem_addr_sel,
  output logic        mem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        psr_we,
  output logic [3:0]  state_out
);

  state_t           state, state_nxt;
  logic             take;
  logic [CLS_W-1:0] cls;
  logic             alu_defined;
  logic             psr_writes;

  // Condition field and register specifiers belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[11:8], instr[3:0]};

  instr_class_decode u_decode (
    .op          (instr[15:12]),
    .ext         (instr[7:4]),
    .cls         (cls),
    .alu_defined (alu_defined),
    .psr_writes  (psr_writes)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      take  <= 1'b0;
    end else begin
      state <= state_nxt;
      // cond_true is only valid while the flags match the decoded instruction.
      if (state == S_DECODE) take <= cond_true;
    end
  end

  always_comb begin
    state_nxt    = S_FETCH;
    ir_we        = 1'b0;
    pc_en        = 1'b0;
    pc_src       = PC_SRC_INC;
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    psr_we       = 1'b0;
    case (state)
      S_FETCH:  state_nxt = run ? S_LATCH : S_FETCH;
      S_LATCH: begin
        ir_we     = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (cls[CLS_LOAD])      state_nxt = S_LD_ADDR;
        else if (cls[CLS_STOR]) state_nxt = S_ST;
        else if (cls[CLS_JCOND] || cls[CLS_JAL] || cls[CLS_BCOND])
                                state_nxt = S_BRANCH;
        else                    state_nxt = S_EXEC;
      end
      S_EXEC: begin
        rf_we  = alu_defined;
        psr_we = alu_defined && psr_writes;
        pc_en  = 1'b1;
      end
      S_LD_ADDR: begin
        mem_addr_sel = 1'b1;
        state_nxt    = S_LD_WB;
      end
      S_LD_WB: begin
        mem_addr_sel = 1'b1;
        rf_we        = 1'b1;
        wb_sel       = WB_MEM;
        pc_en        = 1'b1;
      end
      S_ST: begin
        mem_addr_sel = 1'b1;
        mem_we       = 1'b1;
        pc_en        = 1'b1;
      end
      S_BRANCH: begin
        pc_en = 1'b1;
        if (cls[CLS_JAL]) begin
          pc_src = PC_SRC_REG;
          rf_we  = 1'b1;
          wb_sel = WB_LINK;
        end else if (cls[CLS_JCOND]) begin
          pc_src = take ? PC_SRC_REG : PC_SRC_INC;
        end else begin
          pc_src = take ? PC_SRC_DISP : PC_SRC_INC;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
    // Reset masks the strobes in the same cycle, whatever state we were in.
    if (rst) begin
      ir_we        = 1'b0;
      pc_en        = 1'b0;
      pc_src       = RESET_PC_SEL;
      mem_addr_sel = 1'b0;
      mem_we       = 1'b0;
      rf_we        = 1'b0;
      wb_sel       = WB_ALU;
      psr_we       = 1'b0;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - randomized self-checking bench for cpu_control_fsm
module tb_cpu_control_fsm;
  import cpu_pkg::*;

  localparam logic [1:0] RST_PC = 2'd2;

  localparam int K_PSR   = 0;
  localparam int K_ALU   = 1;
  localparam int K_NOP   = 2;
  localparam int K_LOAD  = 3;
  localparam int K_STOR  = 4;
  localparam int K_JCOND = 5;
  localparam int K_JAL   = 6;
  localparam int K_BCOND = 7;

  logic        clk = 1'b0;
  logic        rst, run, cond_true;
  logic [15:0] instr;
  logic        ir_we, pc_en, mem_addr_sel, mem_we, rf_we, psr_we;
  logic [1:0]  pc_src, wb_sel;
  logic [3:0]  state_out;
  logic [13:0] obs;

  int errors = 0;
  int checks = 0;

  cpu_control_fsm #(.RESET_PC_SEL(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .instr        (instr),
    .cond_true    (cond_true),
    .ir_we        (ir_we),
    .pc_en        (pc_en),
    .pc_src       (pc_src),
    .mem_addr_sel (mem_addr_sel),
    .mem_we       (mem_we),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .psr_we       (psr_we),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  assign obs = {state_out, ir_we, pc_en, pc_src, mem_addr_sel, mem_we, rf_we, wb_sel, psr_we};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ev(logic [3:0] st, bit irw, bit pce, logic [1:0] ps,
                                     bit mas, bit mw, bit rfw, logic [1:0] wb, bit pw);
    return {st, irw, pce, ps, mas, mw, rfw, wb, pw};
  endfunction

  // Instruction kind from the ISA description, written as lookup lists.
  function automatic int classify(logic [15:0] w);
    logic [3:0] op;
    logic [3:0] ext;
    op  = w[15:12];
    ext = w[7:4];
    if (op == 4'h4) begin
      case (ext)
        4'h0:    return K_LOAD;
        4'h4:    return K_STOR;
        4'h8:    return K_JAL;
        4'hC:    return K_JCOND;
        default: return K_NOP;
      endcase
    end
    if (op == 4'hC) return K_BCOND;
    if (op == 4'h0) begin
      if (ext inside {4'h2, 4'h3, 4'h9, 4'hB}) return K_PSR;
      if (ext inside {4'h1, 4'h5, 4'h6, 4'hD}) return K_ALU;
      return K_NOP;
    end
    if (op inside {4'h2, 4'h3, 4'h9, 4'hB}) return K_PSR;
    if (op inside {4'h1, 4'h5, 4'h6, 4'h8, 4'hD, 4'hF}) return K_ALU;
    return K_NOP;
  endfunction

  task automatic cyc(input string tag, input logic [13:0] exp, input bit r, input bit c);
    run       = r;
    cond_true = c;
    @(negedge clk);
    check(tag, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH back to FETCH, preceded by idle park cycles.
  // cd drives cond_true in DECODE, cb in every later cycle; mr is run after FETCH.
  task automatic do_instr(input logic [15:0] w, input bit cd, input bit cb,
                          input int idle, input bit mr);
    int k;
    k = classify(w);
    instr = w;
    for (int i = 0; i < idle; i++) cyc("park", ev(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, cb);
    cyc("fetch",  ev(S_FETCH,  0, 0, 0, 0, 0, 0, 0, 0), 1'b1, cb);
    cyc("latch",  ev(S_LATCH,  1, 0, 0, 0, 0, 0, 0, 0), mr, cb);
    cyc("decode", ev(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0), mr, cd);
    case (k)
      K_PSR:   cyc("exec_psr", ev(S_EXEC, 0, 1, 0, 0, 0, 1, 0, 1), mr, cb);
      K_ALU:   cyc("exec_alu", ev(S_EXEC, 0, 1, 0, 0, 0, 1, 0, 0), mr, cb);
      K_NOP:   cyc("exec_nop", ev(S_EXEC, 0, 1, 0, 0, 0, 0, 0, 0), mr, cb);
      K_LOAD: begin
        cyc("ld_addr", ev(S_LD_ADDR, 0, 0, 0, 1, 0, 0, 0, 0), mr, cb);
        cyc("ld_wb",   ev(S_LD_WB,   0, 1, 0, 1, 0, 1, 1, 0), mr, cb);
      end
      K_STOR:  cyc("st",     ev(S_ST,     0, 1, 0, 1, 1, 0, 0, 0), mr, cb);
      K_BCOND: cyc("bcond",  ev(S_BRANCH, 0, 1, cd ? 2'd1 : 2'd0, 0, 0, 0, 0, 0), mr, cb);
      K_JCOND: cyc("jcond",  ev(S_BRANCH, 0, 1, cd ? 2'd2 : 2'd0, 0, 0, 0, 0, 0), mr, cb);
      default: cyc("jal",    ev(S_BRANCH, 0, 1, 2'd2, 0, 0, 1, 2'd2, 0), mr, cb);
    endcase
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  e;
    rst       = 1'b1;
    run       = 1'b0;
    cond_true = 1'b0;
    instr     = 16'h0521;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'(obs[9:0]), 32'({1'b0, 1'b0, RST_PC, 6'b0}));
    end
    check("reset_state", 32'(state_out), 32'(S_FETCH));
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_instr(16'h0521, 1'b0, 1'b0, 0, 1'b1);
    do_instr(16'h4102, 1'b1, 1'b0, 0, 1'b1);
    do_instr(16'h4143, 1'b0, 1'b1, 1, 1'b1);
    do_instr(16'hC0FE, 1'b1, 1'b0, 0, 1'b1);
    do_instr(16'hC0FE, 1'b0, 1'b1, 0, 1'b1);
    do_instr(16'h4E83, 1'b0, 1'b0, 0, 1'b1);
    do_instr(16'h4ECA, 1'b1, 1'b0, 0, 1'b1);
    // run drops from LATCH onward: LOAD must finish, then park.
    do_instr(16'h4102, 1'b0, 1'b0, 0, 1'b0);
    do_instr(16'h0521, 1'b0, 1'b0, 3, 1'b1);

    // Reset pulse while in ST: strobes masked that cycle, FETCH after.
    instr = 16'h4143;
    cyc("rst_fetch",  ev(S_FETCH,  0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    cyc("rst_latch",  ev(S_LATCH,  1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    cyc("rst_decode", ev(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    rst = 1'b1;
    cyc("rst_in_st",  ev(S_ST,     0, 0, RST_PC, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    rst = 1'b0;
    cyc("rst_after",  ev(S_FETCH,  0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      w = 16'($urandom);
      if (1'($urandom)) begin
        case ($urandom_range(0, 3))
          0:       e = 4'h0;
          1:       e = 4'h4;
          2:       e = 4'h8;
          default: e = 4'hC;
        endcase
        w[15:12] = 4'h4;
        w[7:4]   = e;
      end
      do_instr(w, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
